// File: rtl/rv32_pkg.sv
// Shared RV32 execute-stage definitions: divider op encodings, FSM states, sizes.
package rv32_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned DIV_ITERS = 32;
   localparam int unsigned CNT_W     = 6;

   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic op_is_rem(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
      return n ? (~v + XLEN'(1)) : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division iteration.
module div_step
   import rv32_pkg::*;
(
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] rem_nxt_c,
   output logic [XLEN-1:0] quo_nxt_c
);

   logic [XLEN:0]   rem_sh;
   logic [XLEN+1:0] trial;
   logic            trial_neg;
   logic            unused_trial_bit;

   // Shifted remainder can reach 33 bits, so the trial subtract carries an extra sign bit.
   assign rem_sh           = {rem_i, quo_i[XLEN-1]};
   assign trial            = {1'b0, rem_sh} - {2'b00, divisor_i};
   assign trial_neg        = trial[XLEN+1];
   assign unused_trial_bit = trial[XLEN];

   assign rem_nxt_c = trial_neg ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
   assign quo_nxt_c = {quo_i[XLEN-2:0], ~trial_neg};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) with hazard-unit stall and flush handling.
module div_unit
   import rv32_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_e,
   input  logic [1:0]  div_op_e,
   input  logic [31:0] src_a_e,
   input  logic [31:0] src_b_e,
   input  logic        flush_e,
   output logic        div_stall,
   output logic        div_done,
   output logic [31:0] div_result
);

   logic [1:0]       state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [XLEN-1:0]  rem_q,      rem_d;
   logic [XLEN-1:0]  quo_q,      quo_d;
   logic [XLEN-1:0]  divisor_q,  divisor_d;
   logic [1:0]       op_q,       op_d;
   logic             quo_neg_q,  quo_neg_d;
   logic             rem_neg_q,  rem_neg_d;
   logic [XLEN-1:0]  result_q,   result_d;

   logic [XLEN-1:0]  rem_nxt_c;
   logic [XLEN-1:0]  quo_nxt_c;
   logic             sgn;
   logic             ovf;

   div_step u_div_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (divisor_q),
      .rem_nxt_c (rem_nxt_c),
      .quo_nxt_c (quo_nxt_c)
   );

   assign sgn = op_is_signed(div_op_e);
   assign ovf = sgn && (src_a_e == 32'h8000_0000) && (src_b_e == 32'hFFFF_FFFF);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         divisor_q <= '0;
         op_q      <= '0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         divisor_q <= divisor_d;
         op_q      <= op_d;
         quo_neg_q <= quo_neg_d;
         rem_neg_q <= rem_neg_d;
         result_q  <= result_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      divisor_d = divisor_q;
      op_d      = op_q;
      quo_neg_d = quo_neg_q;
      rem_neg_d = rem_neg_q;
      result_d  = result_q;

      case (state_q)
         ST_IDLE: begin
            if (start_e && !flush_e) begin
               // Divide-by-zero and signed overflow resolve immediately without iterating.
               if (src_b_e == '0) begin
                  result_d = op_is_rem(div_op_e) ? src_a_e : 32'hFFFF_FFFF;
                  state_d  = ST_DONE;
               end else if (ovf) begin
                  result_d = op_is_rem(div_op_e) ? 32'h0 : 32'h8000_0000;
                  state_d  = ST_DONE;
               end else begin
                  op_d      = div_op_e;
                  quo_neg_d = sgn && (src_a_e[31] ^ src_b_e[31]);
                  rem_neg_d = sgn && src_a_e[31];
                  quo_d     = neg_if(src_a_e, sgn && src_a_e[31]);
                  divisor_d = neg_if(src_b_e, sgn && src_b_e[31]);
                  rem_d     = '0;
                  cnt_d     = '0;
                  state_d   = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            if (flush_e) begin
               state_d = ST_IDLE;
            end else begin
               rem_d = rem_nxt_c;
               quo_d = quo_nxt_c;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
                  result_d = op_is_rem(op_q) ? neg_if(rem_nxt_c, rem_neg_q)
                                             : neg_if(quo_nxt_c, quo_neg_q);
                  state_d  = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign div_stall  = ((state_q == ST_IDLE) && start_e && !flush_e) || (state_q == ST_CALC);
   assign div_done   = (state_q == ST_DONE) && !flush_e;
   assign div_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed + random self-checking bench for div_unit using a result scoreboard.
module tb_div_unit;

   logic        clk;
   logic        rst_n;
   logic        start_e;
   logic [1:0]  div_op_e;
   logic [31:0] src_a_e;
   logic [31:0] src_b_e;
   logic        flush_e;
   logic        div_stall;
   logic        div_done;
   logic [31:0] div_result;

   int          n_cmp;
   int          n_bad;
   logic [31:0] sb_q[$];

   div_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_e    (start_e),
      .div_op_e   (div_op_e),
      .src_a_e    (src_a_e),
      .src_b_e    (src_b_e),
      .flush_e    (flush_e),
      .div_stall  (div_stall),
      .div_done   (div_done),
      .div_result (div_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      int signed sa;
      int signed sb;
      sa = a;
      sb = b;
      if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
         return op[1] ? 32'(sa % sb) : 32'(sa / sb);
      end
      return op[1] ? (a % b) : (a / b);
   endfunction

   // Issue one op, hold it while stalled, and check latency, stall length and result.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      int   exp_lat;
      int   stalls;
      int   cyc;
      logic got_done;
      sb_q.push_back(model(op, a, b));
      exp_lat  = ((b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
      stalls   = 0;
      got_done = 1'b0;
      @(negedge clk);
      start_e  = 1'b1;
      div_op_e = op;
      src_a_e  = a;
      src_b_e  = b;
      for (cyc = 0; cyc < 40; cyc++) begin
         #1;
         if (div_done) begin
            got_done = 1'b1;
            break;
         end
         if (div_stall) stalls++;
         @(negedge clk);
      end
      start_e = 1'b0;
      check({tag, "_done_seen"}, 32'(got_done), 32'd1);
      if (got_done) begin
         check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
         check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
         check({tag, "_stall_in_done"}, 32'(div_stall), 32'd0);
         check({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
         if (sb_q.size() != 0) check({tag, "_result"}, div_result, sb_q.pop_front());
      end else begin
         sb_q.delete();
      end
   endtask

   task automatic expect_no_done(input int ncyc, input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         #1;
         if (div_done) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      n_cmp    = 0;
      n_bad    = 0;
      rst_n    = 1'b0;
      start_e  = 1'b0;
      div_op_e = 2'b00;
      src_a_e  = 32'h0;
      src_b_e  = 32'h0;
      flush_e  = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      check("rst_stall", 32'(div_stall), 32'd0);
      check("rst_done", 32'(div_done), 32'd0);
      check("rst_result", div_result, 32'h0);
      rst_n = 1'b1;

      run_op(2'b01, 32'd100, 32'd7, "divu_100_7");
      @(negedge clk);
      #1;
      check("hold_result", div_result, 32'd14);
      check("hold_no_done", 32'(div_done), 32'd0);
      run_op(2'b11, 32'd100, 32'd7, "remu_100_7");
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
      run_op(2'b00, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, "rem_7_m2");
      run_op(2'b00, 32'd5, 32'd0, "div_5_0");
      run_op(2'b10, 32'd5, 32'd0, "rem_5_0");
      run_op(2'b01, 32'hDEAD_BEEF, 32'd0, "divu_x_0");
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
      run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
      run_op(2'b01, 32'hFFFF_FFFF, 32'd1, "divu_max_1");

      // Flush in CALC cycle 10 abandons the op.
      @(negedge clk);
      start_e  = 1'b1;
      div_op_e = 2'b01;
      src_a_e  = 32'd1000;
      src_b_e  = 32'd3;
      repeat (10) @(negedge clk);
      flush_e = 1'b1;
      start_e = 1'b0;
      #1;
      check("flush_cycle_done", 32'(div_done), 32'd0);
      @(negedge clk);
      flush_e = 1'b0;
      #1;
      check("flush_idle_stall", 32'(div_stall), 32'd0);
      expect_no_done(40, "flush_no_done");
      run_op(2'b01, 32'd9, 32'd3, "divu_9_3_after_flush");

      // Start and flush together in IDLE must not start anything.
      @(negedge clk);
      start_e = 1'b1;
      flush_e = 1'b1;
      #1;
      check("idle_flush_stall", 32'(div_stall), 32'd0);
      @(negedge clk);
      start_e = 1'b0;
      flush_e = 1'b0;
      #1;
      check("idle_flush_after", 32'(div_stall), 32'd0);
      expect_no_done(36, "idle_flush_no_done");

      // Reset mid-CALC.
      @(negedge clk);
      start_e  = 1'b1;
      div_op_e = 2'b01;
      src_a_e  = 32'd1000;
      src_b_e  = 32'd7;
      repeat (6) @(negedge clk);
      rst_n   = 1'b0;
      start_e = 1'b0;
      @(negedge clk);
      #1;
      check("midrst_stall", 32'(div_stall), 32'd0);
      check("midrst_done", 32'(div_done), 32'd0);
      check("midrst_result", div_result, 32'h0);
      rst_n = 1'b1;
      expect_no_done(36, "midrst_no_done");
      run_op(2'b01, 32'd1000, 32'd7, "b2b_divu_a");
      run_op(2'b01, 32'd12345, 32'd100, "b2b_divu_b");
      run_op(2'b11, 32'd12345, 32'd100, "b2b_remu_c");

      for (int i = 0; i < 8; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i % 2 == 0) ? $urandom : 32'($signed($urandom_range(0, 40)) - 20);
         run_op(rop, ra, rb, $sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
